uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
//
// PURPOSE
// Receive-side byte FIFO placed directly downstream of uart_rx, in the same clk domain.
// Captures each byte on the rising edge of the receiver's clk_out strobe.
// Buffers up to DEPTH bytes and presents them to the consumer through a valid/ready handshake.
// Also reports fill level and a sticky overflow flag, so slow consumers survive bursts.
//
// PARAMETERS
// DEPTH     16    FIFO capacity in bytes; power of two, DEPTH >= 2
//
// PORTS
// clk           in   1                    system clock, same clock that drives uart_rx
// rst_n         in   1                    asynchronous, active-low reset
// in            in   8                    byte from uart_rx out[8]
// in_stb        in   1                    uart_rx clk_out; rising edge = new byte on in
// out           out  8                    head-of-FIFO byte; 8'h00 when empty
// out_valid     out  1                    high while FIFO non-empty
// out_ready     in   1                    consumer accepts head byte when high with out_valid
// count         out  $clog2(DEPTH)+1      bytes currently stored, 0..DEPTH
// full          out  1                    count == DEPTH
// overflow      out  1                    sticky: a byte was dropped because FIFO was full
// overflow_clr  in   1                    synchronous clear of overflow
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - wptr=0, rptr=0, count=0, overflow=0.
//   - Outputs: out_valid=0, full=0, out=0.
//   - Strobe history register stb_q=1, so a strobe held high across reset release is not captured.
//   - Storage array is not reset.
// - Push detect:
//   - push = in_stb & ~stb_q; stb_q <= in_stb every cycle.
//   - Exactly one push per strobe, however long in_stb stays high.
//   - in is sampled on the push edge; uart_rx makes out stable one cycle before clk_out rises.
// - Pop: pop = out_valid & out_ready.
// - Edge k with push, not full:
//   - mem[wptr] <= in; wptr <= wptr+1, wrapping modulo DEPTH.
// - Edge k with pop:
//   - rptr <= rptr+1, wrapping modulo DEPTH.
// - Count update:
//   - push only: +1.
//   - pop only: -1.
//   - push and pop together: unchanged.
// - Full with push and pop together: the push is accepted, because the pop frees the slot in the same edge.
// - Full with push and no pop:
//   - Byte is dropped; pointers and count are unchanged.
//   - overflow <= 1.
// - Empty with push: the byte is stored and no pop occurs. out_valid rises after the push edge, giving 1-cycle latency from the sampled strobe edge.
// - Output path:
//   - out = mem[rptr] (combinational read) when count != 0, else 8'h00.
//   - out_valid = (count != 0); full = (count == DEPTH).
//   - All three are derived from registers only; no combinational path from in or out_ready.
// - out_ready while empty has no effect; pointers never move on an invalid pop.
// - overflow_clr: overflow <= 0, unless an overflow drop occurs in the same cycle, in which case set wins.
// - Reset mid-operation discards all stored bytes immediately; out_valid drops asynchronously.
// - Ordering is strict FIFO; no byte is duplicated or reordered across pointer wrap.
//
// TESTING
// 1. Strobe in_stb for 1 cycle with in=8'hA5 while empty -> next cycle out_valid=1, out=8'hA5, count=1; pop -> count=0, out=8'h00.
// 2. Hold in_stb high 5 cycles with in=8'h3C -> exactly one byte stored, count=1.
// 3. Push 16 bytes 8'h00..8'h0F without popping -> full=1, count=16; 17th push (8'hFF) -> dropped, overflow=1; pops return 8'h00..8'h0F in order.
// 4. While full, push 8'h77 with out_ready=1 in the same cycle -> count stays 16, head advances, 8'h77 read last.
// 5. Run 40 push/pop pairs with random gaps to exercise pointer wrap -> output sequence equals input sequence; overflow_clr pulse clears overflow, and overflow_clr coincident with a drop leaves overflow=1.
// 6. Assert rst_n=0 with count=5 and in_stb held high through release -> count=0, out_valid=0, no byte captured until the next rising edge of in_stb.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_rx: captures a byte on each rising edge of
// the receiver strobe and hands bytes to the consumer over valid/ready.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               in,
   input  logic                     in_stb,
   output logic [7:0]               out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   input  logic                     overflow_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   cnt;
   logic          stb_q;
   logic          ovf;

   logic push;
   logic pop;
   logic is_full;
   logic accept;

   always_comb begin
      push    = in_stb & ~stb_q;
      pop     = (cnt != '0) & out_ready;
      is_full = (cnt == DEPTH_C);
      // a pop in the same edge frees the slot, so a push while full still lands
      accept  = push & (~is_full | pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         stb_q <= 1'b1;
         ovf   <= 1'b0;
      end else begin
         stb_q <= in_stb;
         if (accept) wptr <= wptr + 1'b1;
         if (pop)    rptr <= rptr + 1'b1;
         case ({accept, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (push & ~accept)    ovf <= 1'b1;
         else if (overflow_clr) ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wptr] <= in;
   end

   always_comb begin
      out       = (cnt != '0) ? mem[rptr] : 8'h00;
      out_valid = (cnt != '0);
      full      = is_full;
      count     = cnt;
      overflow  = ovf;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [7:0]              in;
   logic                    in_stb;
   logic [7:0]              out;
   logic                    out_valid;
   logic                    out_ready;
   logic [$clog2(DEPTH):0]  count;
   logic                    full;
   logic                    overflow;
   logic                    overflow_clr;

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in           (in),
      .in_stb       (in_stb),
      .out          (out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count        (count),
      .full         (full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   logic [7:0] q[$];
   bit         m_prev;
   bit         m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out", 32'(out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
   endtask

   // one clock: apply inputs, advance the reference by the FIFO rules, compare after the edge
   task automatic step(input logic s, input logic [7:0] d, input logic r, input logic c);
      int  sz;
      bit  push, pop, drop;
      in_stb = s; in = d; out_ready = r; overflow_clr = c;
      sz   = q.size();
      push = s && !m_prev;
      pop  = (sz > 0) && r;
      drop = push && (sz == DEPTH) && !pop;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(d);
      if (drop)   m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      m_prev = s;
      #1 check_all();
   endtask

   task automatic push_byte(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
      step(1'b0, d, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; in = 8'h00; in_stb = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
      m_prev = 1'b1; m_ovf = 1'b0;
      #23;
      check_all();
      rst_n = 1'b1;
      #10;

      // single byte, one-cycle latency, then pop
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // long strobe yields a single byte
      for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h3C, 1'b0, 1'b0);
      chk("long_stb_count", 32'(count), 32'd1);
      drain();

      // fill, overflow drop, ordered drain
      for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
      chk("fill_full", 32'(full), 32'd1);
      push_byte(8'hFF);
      chk("drop_ovf", 32'(overflow), 32'd1);
      drain();

      // full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h40 + i));
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("full_pushpop_count", 32'(count), 32'(DEPTH));
      step(1'b0, 8'h00, 1'b0, 1'b0);
      drain();

      // clear racing a drop: set wins; plain clear afterwards
      for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h90 + i));
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("clr_vs_drop", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr", 32'(overflow), 32'd0);
      drain();

      // random traffic across many pointer wraps
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 15) == 0));
      drain();

      // reset mid-operation with strobe held through release
      for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
      in_stb = 1'b1; in = 8'h11;
      #2 rst_n = 1'b0;
      #1;
      q.delete(); m_ovf = 1'b0; m_prev = 1'b1;
      check_all();
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b0, 1'b0);
      chk("no_capture_after_rst", 32'(count), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("capture_after_rst", 32'(out), 32'h5A);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
